student_elastic_register: RTL and testbench
===========================================

STUDENT_ELASTIC_REGISTER -- requirements
Module: student_elastic_register

Interface
REQ-001 Parameter WIDTH, default 16; data word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 2; number of storage entries, legal range 1..8.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port in_data  input  WIDTH  write word.
REQ-006 Port in_valid  input  1  producer offers in_data this cycle.
REQ-007 Port in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port flush  input  1  synchronous discard of all stored entries.
REQ-009 Port out_data  output  WIDTH  oldest stored word.
REQ-010 Port out_valid  output  1  out_data holds a valid word.
REQ-011 Port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 Port count  output  clog2(DEPTH+1)  number of stored entries, 0..DEPTH.

Function
REQ-013 Push occurs iff in_valid and in_ready are both 1 at a rising edge; pop occurs iff out_valid and out_ready are both 1.
REQ-014 Words leave in strict arrival order; no word is duplicated or dropped except by flush or reset.
REQ-015 in_ready = (count != DEPTH) and rst_n; in_ready does not depend on out_ready.
REQ-016 out_valid = (count != 0); out_data = oldest entry when out_valid = 1, else all-zero.
REQ-017 Latency, bypass not compiled in: a word pushed at edge N is presented on out_data from cycle N+1 onward.
REQ-018 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, oldest word leaves, new word joins the tail.
REQ-019 count = DEPTH: no push accepted even if pop occurs in the same cycle; count becomes DEPTH-1 on pop.
REQ-020 count = 0: out_ready is ignored and count never underflows.
REQ-021 Read and write pointers wrap from DEPTH-1 to 0; the DEPTH = 1 case behaves as a single handshaked register.
REQ-022 flush = 1 at an edge: count becomes 0 and both pointers become 0; any push or pop that cycle is discarded; flush has priority over push and pop.
REQ-023 Storage entries load only on push; unaddressed entries hold their value, as in a load-enabled register.

Reset
REQ-024 While rst_n = 0 at an edge: count = 0, pointers = 0, out_valid = 0, out_data = 0, and in_ready = 0 combinationally.
REQ-025 Reset asserted mid-stream discards all stored words; the first word pushed after release is the first word out.
REQ-026 Entry storage contents need no reset; they never reach out_data while count = 0.

Configuration
REQ-027 Macro STUDENT_ELASTIC_BYPASS_EN, when defined: if count = 0 and in_valid = 1, out_valid = 1 and out_data = in_data in the same cycle; if out_ready is also 1, the word passes through with count remaining 0 and nothing stored.
REQ-028 With STUDENT_ELASTIC_BYPASS_EN defined and count = 0, in_valid = 1, out_ready = 0, the word is stored normally and count becomes 1.
REQ-029 Without the macro, behaviour is exactly REQ-016/REQ-017; out_* never depends combinationally on in_*.

Structure
REQ-030 Package student_reg_pkg holds the default-width constant (16) and a function computing the count width from DEPTH.
REQ-031 One sub-module, student_reg_entry, implements a WIDTH-bit register with load enable; DEPTH instances form the storage.
REQ-032 Pointer, count and flush logic reside in student_elastic_register; no other sub-modules.

Verification
REQ-033 Reset, then push 0x1234 with out_ready = 0 -> next cycle out_valid = 1, out_data = 0x1234, count = 1.
REQ-034 DEPTH = 2, push 0xAAAA then 0xBBBB with out_ready = 0 -> count = 2, in_ready = 0; third offer 0xCCCC is not accepted; pops return 0xAAAA then 0xBBBB.
REQ-035 count = 1, simultaneous push 0x0002 and pop -> 0x0001 popped, count stays 1, out_data = 0x0002 next cycle.
REQ-036 count = 2, flush = 1 with in_valid = 1 -> next cycle count = 0, out_valid = 0, out_data = 0x0000.
REQ-037 Push 5 words into DEPTH = 4 with random out_ready stalls for 200 cycles -> output sequence equals input sequence and pointers wrap correctly.
REQ-038 With STUDENT_ELASTIC_BYPASS_EN, empty, in_valid = 1, in_data = 0x5A5A, out_ready = 1 -> out_data = 0x5A5A in the same cycle and count stays 0.

Source files
------------

// File: rtl/student_reg_pkg.sv
// student_reg_pkg: shared constants and sizing helpers for the elastic register.
// Optional bypass path in the top level is enabled with STUDENT_ELASTIC_BYPASS_EN.
package student_reg_pkg;

   // Default data word width for the elastic register and its entries.
   localparam int DEFAULT_WIDTH = 16;

   // Width of the occupancy counter: must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of the read/write pointers: indexes 0..depth-1, at least one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/student_reg_entry.sv
// student_reg_entry: one WIDTH-bit storage word with a load enable.
// Contents are deliberately not reset; the top level never presents an entry
// while it is empty, so stale data is never visible.
module student_reg_entry
   import student_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d only when this entry is the write target; otherwise hold.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/student_elastic_register.sv
// student_elastic_register: DEPTH-entry elastic buffer (small circular FIFO)
// with valid/ready handshakes on both sides, synchronous flush and a
// synchronous active-low reset.
// Optional feature: define STUDENT_ELASTIC_BYPASS_EN to let a word offered to
// an empty buffer appear on the output in the same cycle.
//
// Handshake: a transfer happens on a rising edge exactly when valid and ready
// are both 1 on that side; valid never waits for ready, and in_ready is a
// function of occupancy (and reset) only, never of out_ready.
module student_elastic_register
   import student_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [cnt_width(DEPTH)-1:0]  count
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             bypass_pass;
   logic             store;
   logic             pop_store;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] entry_q    [DEPTH];
   logic             entry_load [DEPTH];

   // Advance a pointer by one, wrapping from DEPTH-1 back to 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;

   // Input side never advertises space during reset, and full blocks a push
   // even when a pop happens in the same cycle.
   assign in_ready = !full && rst_n;
   assign push     = in_valid && in_ready;

`ifdef STUDENT_ELASTIC_BYPASS_EN
   // Empty buffer: the offered word is shown directly; if the consumer takes
   // it in the same cycle it passes through without being stored.
   assign bypass_pass = empty && in_valid && out_ready && rst_n;
   assign out_valid   = !empty || (in_valid && rst_n);
   assign out_data    = !empty ? head : ((in_valid && rst_n) ? in_data : '0);
`else
   // Registered-only output: out_* depends on stored state alone.
   assign bypass_pass = 1'b0;
   assign out_valid   = !empty;
   assign out_data    = empty ? '0 : head;
`endif

   // A push is stored unless it passed straight through or a flush kills it.
   assign store     = push && !bypass_pass && !flush;
   // Only stored words are popped; out_ready is ignored while empty.
   assign pop_store = out_ready && !empty;

   // Select the oldest stored word at the read pointer.
   always_comb begin
      head = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_ptr == PW'(i)) begin
            head = entry_q[i];
         end
      end
   end

   // Storage: one load-enabled register per slot, written at the write pointer.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign entry_load[i] = store && (wr_ptr == PW'(i));

      student_reg_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk  (clk),
         .load (entry_load[i]),
         .d    (in_data),
         .q    (entry_q[i])
      );
   end

   // Pointer and occupancy update; reset and flush clear everything and win
   // over any push or pop in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (store) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop_store) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({store, pop_store})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_student_elastic_register.sv
// tb_student_elastic_register: two instances share clock and reset.
// Lane 0 is DEPTH=2 (directed scenarios), lane 1 is DEPTH=4 (random stalls).
// Each lane keeps a queue of words it expects to come out next.
module tb_student_elastic_register;
   import student_reg_pkg::*;

   localparam int W = 16;
`ifdef STUDENT_ELASTIC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_data   [2];
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic         flush     [2];
   logic [W-1:0] out_data  [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [3:0]   count_w   [2];
   bit           mon_en = 1'b0;
   int           total = 0;
   int           bad = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- DUT lanes + scoreboard monitors ----------------
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int D = (g == 0) ? 2 : 4;
      logic [cnt_width(D)-1:0] cnt_raw;
      logic [W-1:0]            exp_q[$];
      int                      acc_cnt = 0;
      int                      pop_cnt = 0;

      student_elastic_register #(
         .WIDTH (W),
         .DEPTH (D)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (in_data[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .flush     (flush[g]),
         .out_data  (out_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .count     (cnt_raw)
      );

      assign count_w[g] = 4'(cnt_raw);

      // Compare outputs against the queue, then apply the coming edge.
      always @(negedge clk) begin
         int           sz;
         logic         byp_now;
         logic [W-1:0] exp_data;
         string        pfx;
         pfx = (g == 0) ? "d2" : "d4";
         if (mon_en) begin
            sz = exp_q.size();
            byp_now = BYP && rst_n && in_valid[g] && (sz == 0);
            if (sz != 0)      exp_data = exp_q[0];
            else if (byp_now) exp_data = in_data[g];
            else              exp_data = '0;
            check({pfx, "_count"},     64'(count_w[g]),   64'(sz));
            check({pfx, "_in_ready"},  64'(in_ready[g]),  64'(rst_n && (sz != D)));
            check({pfx, "_out_valid"}, 64'(out_valid[g]), 64'((sz != 0) || byp_now));
            check({pfx, "_out_data"},  64'(out_data[g]),  64'(exp_data));
            if (!rst_n || flush[g]) begin
               exp_q.delete();
            end else if (byp_now && out_ready[g]) begin
               acc_cnt++;
               pop_cnt++;
            end else begin
               if (out_ready[g] && (sz != 0)) begin
                  void'(exp_q.pop_front());
                  pop_cnt++;
               end
               if (in_valid[g] && (sz != D)) begin
                  exp_q.push_back(in_data[g]);
                  acc_cnt++;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
      in_valid[k]  = v;
      in_data[k]   = d;
      out_ready[k] = r;
      flush[k]     = f;
   endtask

   task automatic push0(input logic [W-1:0] d);
      drive(0, 1'b1, d, 1'b0, 1'b0);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();
      check("rst_count",     64'(count_w[0]),   64'd0);
      check("rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("rst_out_data",  64'(out_data[0]),  64'd0);
      check("rst_in_ready",  64'(in_ready[0]),  64'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready",  64'(in_ready[0]),  64'd1);

      // single push, output held
      push0(16'h1234);
      check("p1_out_valid", 64'(out_valid[0]), 64'd1);
      check("p1_out_data",  64'(out_data[0]),  64'h1234);
      check("p1_count",     64'(count_w[0]),   64'd1);
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("p1_drained",   64'(count_w[0]),   64'd0);

      // fill DEPTH=2, third offer refused, ordered drain
      push0(16'hAAAA);
      push0(16'hBBBB);
      drive(0, 1'b1, 16'hCCCC, 1'b0, 1'b0);
      #1;
      check("full_count",    64'(count_w[0]),  64'd2);
      check("full_in_ready", 64'(in_ready[0]), 64'd0);
      tick();
      check("full_refused",  64'(count_w[0]),  64'd2);
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      check("pop_first",     64'(out_data[0]), 64'hAAAA);
      tick();
      check("pop_second",    64'(out_data[0]), 64'hBBBB);
      tick();
      check("pop_empty",     64'(count_w[0]),  64'd0);
      drive(0, 1'b0, '0, 1'b0, 1'b0);

      // simultaneous push and pop at count=1
      push0(16'h0001);
      drive(0, 1'b1, 16'h0002, 1'b1, 1'b0);
      #1;
      check("pp_head",  64'(out_data[0]), 64'h0001);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("pp_count", 64'(count_w[0]),  64'd1);
      check("pp_data",  64'(out_data[0]), 64'h0002);

      // flush while full with a push offered
      push0(16'h0003);
      drive(0, 1'b1, 16'h0004, 1'b0, 1'b1);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("fl_count",     64'(count_w[0]),   64'd0);
      check("fl_out_valid", 64'(out_valid[0]), 64'd0);
      check("fl_out_data",  64'(out_data[0]),  64'd0);

      // out_ready while empty does not underflow
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("empty_pop", 64'(count_w[0]), 64'd0);

      // reset mid-stream, first word after release comes out first
      push0(16'h0011);
      push0(16'h0022);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push0(16'h0033);
      check("rst_mid_count", 64'(count_w[0]),  64'd1);
      check("rst_mid_data",  64'(out_data[0]), 64'h0033);
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);

      // empty buffer, word offered with consumer ready
      drive(0, 1'b1, 16'h5A5A, 1'b1, 1'b0);
      #1;
`ifdef STUDENT_ELASTIC_BYPASS_EN
      check("byp_out_valid", 64'(out_valid[0]), 64'd1);
      check("byp_out_data",  64'(out_data[0]),  64'h5A5A);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("byp_count",     64'(count_w[0]),   64'd0);
      // consumer stalled: word is stored instead
      drive(0, 1'b1, 16'h6B6B, 1'b0, 1'b0);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("byp_store_count", 64'(count_w[0]),  64'd1);
      check("byp_store_data",  64'(out_data[0]), 64'h6B6B);
`else
      check("nobyp_out_valid", 64'(out_valid[0]), 64'd0);
      check("nobyp_out_data",  64'(out_data[0]),  64'd0);
      tick();
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      check("nobyp_count",     64'(count_w[0]),   64'd1);
      check("nobyp_data",      64'(out_data[0]),  64'h5A5A);
`endif
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      tick();

      // DEPTH=4 lane: burst with consumer stalled, then random traffic
      for (int c = 0; c < 200; c++) begin
         if (c < 6) drive(1, 1'b1, 16'(16'h0100 + c), 1'b0, 1'b0);
         else drive(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 3) != 0), 1'b0);
         tick();
      end
      drive(1, 1'b0, '0, 1'b1, 1'b0);
      for (int c = 0; c < 8; c++) tick();
      drive(1, 1'b0, '0, 1'b0, 1'b0);
      #1;
      check("rnd_drained",  64'(count_w[1]),     64'd0);
      check("rnd_all_out",  64'(lane[1].pop_cnt), 64'(lane[1].acc_cnt));
      check("rnd_enough",   64'(lane[1].acc_cnt >= 5), 64'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
